// File: rtl/elastic_pipe_reg.sv
// Elastic register pipeline: DEPTH valid/data stages with bubble collapsing,
// global enable, synchronous flush and an occupancy counter.
module elastic_pipe_reg #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] mv;
    logic [DEPTH-1:0] take;
    logic [DEPTH-1:0] leave;
    logic [DW-1:0]    d_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             in_hs;
    logic             out_hs;

    always_comb begin
        mv    = '0;
        take  = '0;
        leave = '0;
        // A stage may take new content if it is empty or its content can move on.
        mv[DEPTH-1] = ~v_q[DEPTH-1] | out_ready;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            mv[i] = ~v_q[i] | ~v_q[i+1] | mv[i+1];
        end

        in_ready  = en & ~flush & ~reset & mv[0];
        out_valid = en & v_q[DEPTH-1];
        in_hs     = in_valid & in_ready;
        out_hs    = out_valid & out_ready;

        take[0] = in_hs;
        for (int i = 1; i < int'(DEPTH); i++) begin
            take[i] = v_q[i-1] & mv[i];
        end
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            leave[i] = v_q[i] & mv[i+1];
        end
        leave[DEPTH-1] = out_hs;

        v_d     = take | (v_q & ~leave);
        count_d = count_q + CW'(in_hs) - CW'(out_hs);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= '0;
            end
        end else if (flush) begin
            // Data registers deliberately keep their contents.
            v_q     <= '0;
            count_q <= '0;
        end else if (en) begin
            v_q     <= v_d;
            count_q <= count_d;
            if (take[0]) begin
                d_q[0] <= in_data;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (take[i]) begin
                    d_q[i] <= d_q[i-1];
                end
            end
        end
    end

    assign out_data = d_q[DEPTH-1];
    assign count    = count_q;

    count_matches_valids: assert property (@(posedge clk_in) disable iff (reset)
        count_q == CW'($countones(v_q)));

    count_in_range: assert property (@(posedge clk_in) disable iff (reset)
        32'(count_q) <= DEPTH);

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: DEPTH=3 and DEPTH=1 instances checked every cycle
// against a queue-of-beats reference model.
module tb_elastic_pipe_reg;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       sel;
    logic       rst_a;
    logic       rst_b;

    assign rst_a = reset | sel;
    assign rst_b = reset | ~sel;

    logic       ir3, ov3, ir1, ov1;
    logic [7:0] od3, od1;
    logic [1:0] cnt3;
    logic [0:0] cnt1;

    elastic_pipe_reg #(.DW(8), .DEPTH(3)) u_dut3 (
        .clk_in    (clk),
        .reset     (rst_a),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (ir3),
        .in_data   (in_data),
        .out_valid (ov3),
        .out_ready (out_ready),
        .out_data  (od3),
        .count     (cnt3)
    );

    elastic_pipe_reg #(.DW(8), .DEPTH(1)) u_dut1 (
        .clk_in    (clk),
        .reset     (rst_b),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (ir1),
        .in_data   (in_data),
        .out_valid (ov1),
        .out_ready (out_ready),
        .out_data  (od1),
        .count     (cnt1)
    );

    logic       dut_ir, dut_ov;
    logic [7:0] dut_od;
    int         dut_cnt;

    assign dut_ir  = sel ? ir1 : ir3;
    assign dut_ov  = sel ? ov1 : ov3;
    assign dut_od  = sel ? od1 : od3;
    assign dut_cnt = sel ? int'(cnt1) : int'(cnt3);

    // Reference model: beats in FIFO order, each with its stage position.
    typedef struct {
        logic [7:0] data;
        int         pos;
    } beat_t;

    beat_t      mq[$];
    int         depth;
    logic [7:0] last_out;
    int         n_checks = 0;
    int         n_fail = 0;
    int         full_drain = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_in_ready();
        return en & ~flush & ~reset & ((mq.size() < depth) | out_ready);
    endfunction

    function automatic logic exp_out_valid();
        return en & (mq.size() > 0) && (mq[0].pos == depth - 1);
    endfunction

    task automatic model_step();
        logic  acc;
        int    limit;
        int    np;
        beat_t b;
        if (reset) begin
            mq.delete();
            last_out = 8'h00;
            return;
        end
        if (flush) begin
            mq.delete();
            return;
        end
        if (!en) return;
        acc = in_valid & exp_in_ready();
        if (exp_out_valid() && out_ready) void'(mq.pop_front());
        limit = depth - 1;
        for (int i = 0; i < mq.size(); i++) begin
            b  = mq[i];
            np = (b.pos + 1 < limit) ? b.pos + 1 : limit;
            if (np == depth - 1 && b.pos != depth - 1) last_out = b.data;
            b.pos = np;
            mq[i] = b;
            limit = np - 1;
        end
        if (acc) begin
            b.data = in_data;
            b.pos  = 0;
            if (limit < 0) check_eq("model_slot", 32'(limit), 32'd0);
            if (depth == 1) last_out = in_data;
            mq.push_back(b);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_eq("in_ready", 32'(dut_ir), 32'(exp_in_ready()));
        check_eq("out_valid", 32'(dut_ov), 32'(exp_out_valid()));
        check_eq("out_data", 32'(dut_od), 32'(last_out));
        check_eq("count", 32'(dut_cnt), 32'(mq.size()));
        if (dut_cnt == depth && dut_ir && in_valid && dut_ov && out_ready) full_drain++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        sel   = 1'b0;
        depth = 3;
        reset = 1'b1;
        en    = 1'b0;
        flush = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        last_out = 8'h00;
        en = 1'b1;
        cycle();
        reset = 1'b0;

        // Single beat latency
        drive(1'b1, 8'hA1, 1'b1);
        cycle();
        in_valid = 1'b0;
        repeat (4) cycle();

        // Sustained stream
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 8'(k), 1'b1);
            cycle();
        end
        in_valid = 1'b0;
        repeat (4) cycle();

        // Output stalled: bubbles collapse, then release in order
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 8'(k), 1'b0);
            cycle();
        end
        drive(1'b0, 8'h00, 1'b1);
        repeat (5) cycle();

        // Full pipe frozen by en=0
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'h30 + 8'(k), 1'b0);
            cycle();
        end
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(k[0], 8'h77, ~k[0]);
            cycle();
        end
        en = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        repeat (5) cycle();

        // Flush at count=2 with in_valid high
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 8'h50 + 8'(k), 1'b0);
            cycle();
        end
        drive(1'b1, 8'h5F, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        repeat (3) cycle();

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            en    = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
            cycle();
        end
        en    = 1'b1;
        flush = 1'b0;

        // Switch to the single-stage instance
        sel = 1'b1;
        mq.delete();
        last_out = 8'h00;
        depth    = 1;
        reset    = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        cycle();
        reset = 1'b0;
        full_drain = 0;
        for (int k = 0; k < 200; k++) begin
            drive(($urandom_range(0, 7) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
            cycle();
        end
        check_eq("full_accept_drain_seen", 32'(full_drain > 0), 32'd1);

        // Reset mid-stream
        drive(1'b1, 8'hC3, 1'b0);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
